// File: rtl/tim_pkg.sv
// tim_pkg: shared constants for the multi-channel APB timer.
// Register map, CTRL bit positions and channel state.
package tim_pkg;

  localparam int CH_STRIDE = 20;

  localparam logic [7:0] OFF_LOAD    = 8'h00;
  localparam logic [7:0] OFF_CURVAL  = 8'h04;
  localparam logic [7:0] OFF_CTRL    = 8'h08;
  localparam logic [7:0] OFF_EOI     = 8'h0C;
  localparam logic [7:0] OFF_INTSTAT = 8'h10;

  localparam logic [7:0] G_INTSTAT = 8'hA0;
  localparam logic [7:0] G_EOI     = 8'hA4;
  localparam logic [7:0] G_RAW     = 8'hA8;

  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_IMASK   = 2;
  localparam int CTRL_ONESHOT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_st_e;

  // byte address of register `off` in channel `n`
  function automatic logic [7:0] chan_addr(
    input int         n,
    input logic [7:0] off
  );
    return 8'(n * CH_STRIDE) + off;
  endfunction

endpackage

// File: rtl/tim_nch_if.sv
// tim_nch_if: zero-wait-state APB bus bundle for the timer.
// master drives the request, slave returns prdata.
interface tim_nch_if;
  import tim_pkg::*;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic [31:0] prdata;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata, pprot,
    input  prdata
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata, pprot,
    output prdata
  );

endinterface

// File: rtl/tim_nch_chan.sv
// tim_nch_chan: one down-counting timer channel.
// Holds LOAD, CTRL, counter, raw status, trigger enable.
module tim_nch_chan
  import tim_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_we,
  input  logic              i_ctrl_we,
  input  logic [CNT_W-1:0]  i_wdata,
  input  logic              i_eoi,
  input  logic              i_trig_on,
  input  logic              i_trig_off,
  output logic [CNT_W-1:0]  o_load,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_raw,
  output logic              o_intr,
  output logic              o_trig
);

  chan_st_e          r_st;
  logic [CNT_W-1:0]  r_load;
  logic [CNT_W-1:0]  r_cnt;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_raw;
  logic              r_ten;
  logic              r_trig;

  logic              w_en;
  logic              w_tmo;
  logic              w_one;
  logic [CNT_W-1:0]  w_reload;

  // EN as seen by this edge: a CTRL write acts at once
  always_comb begin
    w_en     = i_ctrl_we ? i_wdata[CTRL_EN]
                         : r_ctrl[CTRL_EN];
    w_tmo    = (r_st == ST_RUN) && w_en &&
               (r_cnt == '0);
    w_one    = r_ctrl[CTRL_ONESHOT];
    w_reload = r_ctrl[CTRL_MODE] ? r_load : '1;
  end

  // software registers; one-shot timeout drops EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load <= '0;
      r_ctrl <= '0;
    end else begin
      if (i_load_we)
        r_load <= i_wdata;
      if (i_ctrl_we)
        r_ctrl <= i_wdata[CTRL_W-1:0];
      if (w_tmo && w_one)
        r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // channel state and down counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (w_en) begin
            r_st  <= ST_RUN;
            r_cnt <= r_load;
          end
        end
        ST_RUN: begin
          if (!w_en) begin
            r_st <= ST_IDLE;
          end else if (w_tmo && w_one) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
          end else if (w_tmo) begin
            r_cnt <= w_reload;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  // status: a timeout beats a coincident EOI clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_raw  <= 1'b0;
      r_ten  <= 1'b0;
      r_trig <= 1'b0;
    end else begin
      if (w_tmo)
        r_raw <= 1'b1;
      else if (i_eoi)
        r_raw <= 1'b0;
      if (i_trig_off)
        r_ten <= 1'b0;
      else if (i_trig_on)
        r_ten <= 1'b1;
      r_trig <= w_tmo & r_ten;
    end
  end

  assign o_load = r_load;
  assign o_cnt  = r_cnt;
  assign o_ctrl = r_ctrl;
  assign o_raw  = r_raw;
  assign o_intr = r_raw & ~r_ctrl[CTRL_IMASK];
  assign o_trig = r_trig;

endmodule

// File: rtl/tim_nch_top.sv
// tim_nch_top: NCH-channel APB timer, decode and read mux.
// Optional TIM_SEC_CHECK_EN blocks non-secure access.
module tim_nch_top
  import tim_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic           pclk,
  input  logic           presetn,
  tim_nch_if.slave       bus,
  input  logic           tipc_trust,
  input  logic           scan_mode,
  input  logic [NCH-1:0] etb_trig_en_on,
  input  logic [NCH-1:0] etb_trig_en_off,
  output logic [NCH-1:0] intr,
  output logic [NCH-1:0] etb_trig
);

  logic              w_block;
  logic              w_wr;
  logic              w_rd;
  logic              w_rd_acc;
  logic              w_geoi;
  logic [7:0]        w_a;
  logic [NCH-1:0]    w_load_we;
  logic [NCH-1:0]    w_ctrl_we;
  logic [NCH-1:0]    w_eoi;
  logic [NCH-1:0]    w_raw;
  logic [NCH-1:0]    w_intr;
  logic [NCH-1:0]    w_trig;
  logic [CNT_W-1:0]  w_load [NCH];
  logic [CNT_W-1:0]  w_cnt  [NCH];
  logic [CTRL_W-1:0] w_ctrl [NCH];
  logic [31:0]       w_rdata;
  logic              w_unused;

`ifdef TIM_SEC_CHECK_EN
  assign w_block = tipc_trust & bus.pprot[1];
`else
  assign w_block = 1'b0;
`endif

  assign w_unused = ^{scan_mode, tipc_trust,
                      bus.pprot, bus.paddr[31:8],
                      bus.pwdata};

  assign w_a = bus.paddr[7:0];

  // per-channel write strobes and EOI clears
  always_comb begin
    w_wr     = bus.psel & bus.penable &
               bus.pwrite & ~w_block;
    w_rd     = bus.psel & ~bus.pwrite & ~w_block;
    w_rd_acc = w_rd & bus.penable;
    w_geoi   = w_rd_acc && (w_a == G_EOI);
    for (int n = 0; n < NCH; n++) begin
      w_load_we[n] = w_wr &&
        (w_a == chan_addr(n, OFF_LOAD));
      w_ctrl_we[n] = w_wr &&
        (w_a == chan_addr(n, OFF_CTRL));
      w_eoi[n] = w_geoi || (w_rd_acc &&
        (w_a == chan_addr(n, OFF_EOI)));
    end
  end

  // combinational read mux, zero when unmapped
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      for (int n = 0; n < NCH; n++) begin
        if (w_a == chan_addr(n, OFF_LOAD))
          w_rdata = 32'(w_load[n]);
        if (w_a == chan_addr(n, OFF_CURVAL))
          w_rdata = 32'(w_cnt[n]);
        if (w_a == chan_addr(n, OFF_CTRL))
          w_rdata = 32'(w_ctrl[n]);
        if (w_a == chan_addr(n, OFF_EOI))
          w_rdata = 32'(w_raw[n]);
        if (w_a == chan_addr(n, OFF_INTSTAT))
          w_rdata = 32'(w_intr[n]);
      end
      unique case (1'b1)
        (w_a == G_INTSTAT): w_rdata = 32'(w_intr);
        (w_a == G_EOI):     w_rdata = 32'(w_raw);
        (w_a == G_RAW):     w_rdata = 32'(w_raw);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tim_nch_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .i_clk      (pclk),
      .i_rst_n    (presetn),
      .i_load_we  (w_load_we[g]),
      .i_ctrl_we  (w_ctrl_we[g]),
      .i_wdata    (bus.pwdata[CNT_W-1:0]),
      .i_eoi      (w_eoi[g]),
      .i_trig_on  (etb_trig_en_on[g]),
      .i_trig_off (etb_trig_en_off[g]),
      .o_load     (w_load[g]),
      .o_cnt      (w_cnt[g]),
      .o_ctrl     (w_ctrl[g]),
      .o_raw      (w_raw[g]),
      .o_intr     (w_intr[g]),
      .o_trig     (w_trig[g])
    );
  end

  assign bus.prdata = w_rdata;
  assign intr       = w_intr;
  assign etb_trig   = w_trig;

endmodule

// File: tb/tb_tim_nch_top.sv
// tb_tim_nch_top: random + directed bench for tim_nch_top.
// Reference model tracks timeout deadlines as cycle numbers.
module tb_tim_nch_top;

  localparam int     NCH   = 4;
  localparam int     CNT_W = 16;
  localparam longint CMAX  = (longint'(1) << CNT_W) - 1;

  logic           pclk       = 1'b0;
  logic           presetn    = 1'b0;
  logic           tipc_trust = 1'b0;
  logic           scan_mode  = 1'b0;
  logic [NCH-1:0] on_p       = '0;
  logic [NCH-1:0] off_p      = '0;
  logic [NCH-1:0] intr;
  logic [NCH-1:0] etb_trig;

  tim_nch_if bus ();

  tim_nch_top #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .bus             (bus),
    .tipc_trust      (tipc_trust),
    .scan_mode       (scan_mode),
    .etb_trig_en_on  (on_p),
    .etb_trig_en_off (off_p),
    .intr            (intr),
    .etb_trig        (etb_trig)
  );

  always #5 pclk = ~pclk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint k       = 0;

  bit          m_run  [NCH];
  longint      m_due  [NCH];
  longint      m_hold [NCH];
  logic [31:0] m_load [NCH];
  logic [3:0]  m_ctrl [NCH];
  bit          m_raw  [NCH];
  bit          m_ten  [NCH];
  bit          m_trig [NCH];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit blocked();
`ifdef TIM_SEC_CHECK_EN
    return tipc_trust && bus.pprot[1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_cur(int c);
    if (m_run[c])
      return 32'(m_due[c] - k - 1);
    return 32'(m_hold[c]);
  endfunction

  function automatic bit m_int(int c);
    return m_raw[c] && !m_ctrl[c][2];
  endfunction

  // which: 0 raw, 1 masked, 2 trigger pulse
  function automatic logic [31:0] m_vec(int which);
    logic [31:0] v = '0;
    for (int c = 0; c < NCH; c++)
      v[c] = (which == 0) ? m_raw[c] :
             (which == 1) ? m_int(c) : m_trig[c];
    return v;
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    if (blocked()) return '0;
    for (int c = 0; c < NCH; c++) begin
      if (a == 8'(c * 20))      return m_load[c];
      if (a == 8'(c * 20 + 4))  return m_cur(c);
      if (a == 8'(c * 20 + 8))  return 32'(m_ctrl[c]);
      if (a == 8'(c * 20 + 12)) return 32'(m_raw[c]);
      if (a == 8'(c * 20 + 16)) return 32'(m_int(c));
    end
    if (a == 8'hA0) return m_vec(1);
    if (a == 8'hA4) return m_vec(0);
    if (a == 8'hA8) return m_vec(0);
    return '0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]  = 0;
      m_due[c]  = 0;
      m_hold[c] = 0;
      m_load[c] = '0;
      m_ctrl[c] = '0;
      m_raw[c]  = 0;
      m_ten[c]  = 0;
      m_trig[c] = 0;
    end
    k = 0;
  endtask

  // apply the inputs present now to the coming edge
  task automatic model_edge();
    logic [7:0] a   = bus.paddr[7:0];
    bit         acc = bus.psel && bus.penable && !blocked();
    bit         wr  = acc && bus.pwrite;
    bit         rd  = acc && !bus.pwrite;
    longint     e   = k + 1;
    for (int c = 0; c < NCH; c++) begin
      bit wl  = wr && (a == 8'(c * 20));
      bit wc  = wr && (a == 8'(c * 20 + 8));
      bit eoi = rd && (a == 8'(c * 20 + 12) ||
                       a == 8'hA4);
      bit en  = wc ? bus.pwdata[0] : m_ctrl[c][0];
      bit tmo = m_run[c] && en && (m_due[c] == e);
      bit one = m_ctrl[c][3];
      longint per;
      per = m_ctrl[c][1] ? longint'(m_load[c]) : CMAX;
      if (!m_run[c] && en) begin
        m_run[c] = 1;
        m_due[c] = e + longint'(m_load[c]) + 1;
      end else if (m_run[c] && !en) begin
        m_run[c]  = 0;
        m_hold[c] = m_due[c] - e;
      end else if (tmo && one) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end else if (tmo) begin
        m_due[c] = e + per + 1;
      end
      m_trig[c] = tmo && m_ten[c];
      if (tmo) m_raw[c] = 1;
      else if (eoi) m_raw[c] = 0;
      if (off_p[c]) m_ten[c] = 0;
      else if (on_p[c]) m_ten[c] = 1;
      if (wc) m_ctrl[c] = bus.pwdata[3:0];
      if (tmo && one) m_ctrl[c][0] = 1'b0;
      if (wl) m_load[c] = bus.pwdata & 32'(CMAX);
    end
    k = e;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge pclk);
    @(negedge pclk);
    check("intr", 32'(intr), m_vec(1));
    check("etb_trig", 32'(etb_trig), m_vec(2));
  endtask

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a,
                        input logic [31:0] d);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = a;
    bus.pwdata  = d;
    cyc();
    bus.penable = 1'b1;
    cyc();
    bus_idle();
  endtask

  task automatic apb_rd(input logic [31:0] a,
                        input string tag,
                        output logic [31:0] got);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = a;
    #1;
    check({tag, "_setup"}, bus.prdata, m_read(a[7:0]));
    cyc();
    bus.penable = 1'b1;
    #1;
    got = bus.prdata;
    check(tag, got, m_read(a[7:0]));
    cyc();
    bus_idle();
  endtask

  task automatic pulse(input logic [NCH-1:0] on,
                       input logic [NCH-1:0] off);
    on_p  = on;
    off_p = off;
    cyc();
    on_p  = '0;
    off_p = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          cnt;
    int          guard;
    bus_idle();
    bus.paddr  = '0;
    bus.pwdata = '0;
    bus.pprot  = 3'b000;
    model_reset();

    #1;
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_trig", 32'(etb_trig), 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    for (int a = 0; a < 8'hB0; a += 20)
      apb_rd(32'(a + 8), "rst_ctrl", got);

    // ch0: LOAD=3 reload mode, trigger initially disabled
    apb_wr(32'h00, 32'd3);
    apb_wr(32'h08, 32'h3);
    cnt = 0;
    repeat (8) begin
      cyc();
      cnt += int'(etb_trig[0]);
    end
    check("trig_off_cnt", 32'(cnt), 32'd0);
    check("intr0_after_tmo", 32'(intr[0]), 32'd1);
    pulse(4'b0001, 4'b0000);
    cnt = 0;
    repeat (16) begin
      cyc();
      cnt += int'(etb_trig[0]);
    end
    check("trig_on_cnt", 32'(cnt), 32'd4);

    // EOI access edge lands on a timeout edge
    guard = 0;
    while (!(m_run[0] && m_due[0] == k + 2) &&
           guard < 20) begin
      cyc();
      guard++;
    end
    check("coin_sync", 32'(guard < 20), 32'd1);
    apb_rd(32'h0C, "coin_eoi", got);
    check("coin_raw", 32'(intr[0]), 32'd1);
    apb_wr(32'h08, 32'h2);
    apb_rd(32'h0C, "eoi2", got);
    check("eoi2_intr", 32'(intr[0]), 32'd0);

    // ch1 one-shot, LOAD=5
    apb_wr(32'h14, 32'd5);
    apb_wr(32'h1C, 32'hB);
    cnt = 0;
    while (!intr[1] && cnt < 20) begin
      cyc();
      cnt++;
    end
    check("os_latency", 32'(cnt), 32'd6);
    apb_rd(32'h1C, "os_ctrl", got);
    check("os_en", 32'(got[0]), 32'd0);
    apb_rd(32'h18, "os_cur", got);
    check("os_cur0", got, 32'd0);
    apb_rd(32'h20, "os_eoi", got);
    repeat (12) cyc();
    check("os_single", 32'(intr[1]), 32'd0);

    // ch2: on and off together leaves trigger disabled
    apb_wr(32'h28, 32'd1);
    apb_wr(32'h30, 32'h3);
    pulse(4'b0100, 4'b0100);
    cnt = 0;
    repeat (10) begin
      cyc();
      cnt += int'(etb_trig[2]);
    end
    check("onoff_trig", 32'(cnt), 32'd0);

    // non-secure write to ch3 LOAD with trusted group
    tipc_trust = 1'b1;
    bus.pprot  = 3'b010;
    apb_wr(32'h3C, 32'h10);
    apb_rd(32'h3C, "ns_read", got);
    bus.pprot  = 3'b000;
    apb_rd(32'h3C, "sec_read", got);
`ifdef TIM_SEC_CHECK_EN
    check("sec_load", got, 32'h0);
`else
    check("sec_load", got, 32'h10);
`endif
    tipc_trust = 1'b0;

    // randomized traffic
    repeat (400) begin
      int          op;
      int          c;
      int          sel;
      logic [31:0] a;
      logic [31:0] hi;
      op  = int'($urandom_range(0, 9));
      c   = int'($urandom_range(0, NCH - 1));
      sel = int'($urandom_range(0, 3));
      hi  = $urandom & 32'hFFFF_FF00;
      if (sel < 2)
        a = hi | 32'(c * 20 + 4 * $urandom_range(0, 4));
      else if (sel == 2)
        a = hi | 32'(8'hA0 + 4 * $urandom_range(0, 2));
      else
        a = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        tipc_trust = 1'b1;
        bus.pprot  = 3'($urandom);
      end
      case (op)
        0, 1, 2:
          apb_wr(32'(c * 20), ($urandom & 32'hFFFF_0000) |
                 32'($urandom_range(0, 9)));
        3, 4:
          apb_wr(32'(c * 20 + 8), ($urandom & 32'hFFFF_FFF0) |
                 32'($urandom_range(0, 15)));
        5, 6:
          apb_rd(a, "rnd_rd", got);
        7:
          pulse(NCH'($urandom), NCH'($urandom));
        8:
          repeat ($urandom_range(1, 5)) cyc();
        default:
          apb_wr(a, $urandom);
      endcase
      tipc_trust = 1'b0;
      bus.pprot  = 3'b000;
    end

    // all channels counting, then reset mid-count
    for (int c = 0; c < NCH; c++) begin
      apb_wr(32'(c * 20), 32'd2);
      apb_wr(32'(c * 20 + 8), 32'h3);
    end
    pulse('1, '0);
    repeat (5) cyc();
    presetn = 1'b0;
    #1;
    check("mid_rst_intr", 32'(intr), 32'h0);
    check("mid_rst_trig", 32'(etb_trig), 32'h0);
    bus.psel   = 1'b1;
    bus.pwrite = 1'b0;
    for (int a = 0; a < 8'hB0; a += 4) begin
      bus.paddr = 32'(a);
      #1;
      check("mid_rst_rd", bus.prdata, 32'h0);
    end
    bus_idle();
    model_reset();
    repeat (3) begin
      @(posedge pclk);
      @(negedge pclk);
      check("rst_hold_trig", 32'(etb_trig), 32'h0);
    end
    presetn = 1'b1;
    repeat (8) cyc();
    for (int a = 0; a < 8'hB0; a += 4)
      apb_rd(32'(a), "post_rst_rd", got);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tim_nch_top.md
TIM_NCH_TOP -- requirements
Module: tim_nch_top

Interface
REQ-001 The block SHALL have one clock and one reset: a single clock `pclk`; reset `presetn`, asynchronous, active-low.
REQ-002 Parameter NCH, default 2, SHALL set the channel count; legal range 1..8.
REQ-003 Parameter CNT_W, default 32, SHALL set the counter width; legal range 8..32.
REQ-004 pclk  in  1  APB and counter clock.
REQ-005 presetn  in  1  async active-low reset.
REQ-006 psel/penable/pwrite  in  1 each  APB control.
REQ-007 paddr  in  32  byte address, bits [7:0] decoded; pwdata  in  32  write data.
REQ-008 pprot  in  3  APB protection; tipc_trust  in  1  channel-group is secure-only.
REQ-009 prdata  out  32  read data.
REQ-010 scan_mode  in  1  port compatibility only, no function.
REQ-011 etb_trig_en_on / etb_trig_en_off  in  NCH  per-channel one-cycle pulses that set / clear the trigger enable.
REQ-012 intr  out  NCH  level interrupt per channel; etb_trig  out  NCH  one-cycle timeout pulse per channel.

Function
REQ-013 APB transfers SHALL have zero wait states.
REQ-014 Writes SHALL commit on psel&penable&pwrite.
REQ-015 prdata SHALL be driven combinationally when psel&~pwrite.
REQ-016 Unmapped addresses SHALL read 0 and ignore writes.
REQ-017 Channel n registers SHALL sit at base 0x14*n: LOAD 0x00 RW; CURVAL 0x04 RO; CTRL 0x08 RW; EOI 0x0C RO; INTSTAT 0x10 RO.
REQ-018 CTRL bits SHALL be: [0] EN, [1] MODE (0 free-run reload all-ones, 1 reload LOAD), [2] IMASK, [3] ONESHOT.
REQ-019 Global registers SHALL be: 0xA0 masked status of all channels; 0xA4 read clears all channels; 0xA8 raw status.
REQ-020 Per-channel state SHALL be IDLE (EN=0, counter held) or RUN.
REQ-021 IDLE->RUN SHALL occur on the first edge with EN=1, loading counter<=LOAD.
REQ-022 RUN->IDLE SHALL occur when EN is written 0; the counter holds its value.
REQ-023 In RUN, the counter SHALL decrement by 1 per pclk.
REQ-024 At counter==0 in RUN, the next edge SHALL reload (LOAD or all-ones per MODE), set raw status, and pulse etb_trig[n] for one cycle if its trigger enable is set; period = LOAD+1 cycles.
REQ-025 With ONESHOT=1, at timeout the hardware SHALL clear EN and return the channel to IDLE with counter 0.
REQ-026 LOAD=0 SHALL give a timeout every cycle.
REQ-027 LOAD written while in RUN SHALL take effect at the next reload only.
REQ-028 Counter and LOAD SHALL be CNT_W bits, zero-extended on read; upper write bits are ignored.
REQ-029 intr[n] SHALL equal raw[n] & ~IMASK[n], registered-free from raw.
REQ-030 An EOI read (psel&penable&~pwrite) SHALL return the status and clear raw on the same edge.
REQ-031 A timeout coincident with an EOI read SHALL leave raw set.
REQ-032 etb_trig_en_on[n] SHALL set the trigger enable and etb_trig_en_off[n] SHALL clear it; when both are asserted together, off wins.

Reset
REQ-033 presetn low SHALL clear all LOAD, CTRL, counters, raw status and trigger enables, and force all channels to IDLE.
REQ-034 While presetn is low, intr=0, etb_trig=0 and prdata=0 when idle.
REQ-035 Reset mid-count SHALL abort immediately; no etb_trig pulse is produced.

Configuration
REQ-036 Macro TIM_SEC_CHECK_EN defined: when tipc_trust=1 and pprot[1]=1 (non-secure), writes SHALL be dropped and reads SHALL return 0 with no EOI side effect.
REQ-037 Macro TIM_SEC_CHECK_EN undefined: pprot and tipc_trust SHALL be ignored.

Structure
REQ-038 Package tim_pkg SHALL hold the register offsets, CTRL bit indices, channel stride 0x14, global offsets, and the channel state enum.
REQ-039 Sub-module tim_nch_chan SHALL implement one channel (counter, state, raw status, trigger enable) and be instantiated NCH times via generate; the top holds APB decode and read mux.

Verification
REQ-040 LOAD=3, CTRL=0x3 on ch0 -> etb_trig[0] SHALL not pulse while the trigger enable is clear; after an en_on pulse, etb_trig[0] and the raw status update SHALL occur every 4 cycles; intr[0]=1 after the first timeout.
REQ-041 ONESHOT with LOAD=5 -> exactly one timeout 6 cycles after EN, after which CTRL.EN reads 0 and CURVAL reads 0.
REQ-042 EOI read in the same cycle as a timeout -> raw SHALL remain 1; a second EOI read SHALL clear intr.
REQ-043 en_on and en_off pulsed together -> trigger enable SHALL be 0 and no etb_trig pulse SHALL occur.
REQ-044 Macro defined, tipc_trust=1, pprot=3'b010, write LOAD=0x10 -> LOAD SHALL read back as 0 via a secure read.
REQ-045 presetn asserted mid-count with NCH=4 -> all outputs SHALL be 0 and all registers SHALL read 0.
